// File: rtl/accum_alu_if.sv
// Operand/command and result/flag bundle between the operand bus and accum_alu.
// The master drives commands; the slave (accum_alu) returns the accumulator and flags.
interface accum_alu_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic             Cin;
  logic [3:0]       Mode;
  logic             Start;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Hi;
  logic             CBF;
  logic             Of;
  logic             Zf;
  logic             Busy;
  logic             Done;

  modport master (
    output A, Cin, Mode, Start,
    input  Y, Hi, CBF, Of, Zf, Busy, Done
  );

  modport slave (
    input  A, Cin, Mode, Start,
    output Y, Hi, CBF, Of, Zf, Busy, Done
  );
endinterface

// File: rtl/accum_alu.sv
// Parametrised accumulator ALU/shifter with flags and a multi-cycle shift-add MUL.
// All state updates happen on the falling edge of Clk.
module accum_alu #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 3
) (
  input logic        Clk,
  input logic        nReset,
  accum_alu_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] M_NOP = 4'd0,  M_LOAD = 4'd1,  M_ADD = 4'd2,  M_ADC = 4'd3;
  localparam logic [3:0] M_SUB = 4'd4,  M_SBB  = 4'd5,  M_AND = 4'd6,  M_OR  = 4'd7;
  localparam logic [3:0] M_XOR = 4'd8,  M_NOT  = 4'd9,  M_SHL = 4'd10, M_SHR = 4'd11;
  localparam logic [3:0] M_ASR = 4'd12, M_ROL  = 4'd13, M_ROR = 4'd14, M_MUL = 4'd15;

  state_t           state_p0;
  logic [WIDTH-1:0] y_p0, hi_p0;
  logic             cbf_p0, of_p0, zf_p0, busy_p0, done_p0;
  logic [CNTW-1:0]  cnt_p0;
  logic [WIDTH-1:0] mcand_p0, mplier_p0, part_p0;

  logic [WIDTH-1:0] res;
  logic             cbf_n, of_n;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_lo, mul_hi;

  // Returns {carry, overflow, sum} of acc + a + cin.
  function automatic logic [WIDTH+1:0] add_f(input logic [WIDTH-1:0] acc,
                                             input logic [WIDTH-1:0] a,
                                             input logic             cin);
    logic [WIDTH:0] s;
    logic           ovf;
    s   = {1'b0, acc} + {1'b0, a} + {{WIDTH{1'b0}}, cin};
    ovf = (acc[WIDTH-1] == a[WIDTH-1]) && (s[WIDTH-1] != acc[WIDTH-1]);
    return {s[WIDTH], ovf, s[WIDTH-1:0]};
  endfunction

  // Returns {borrow, overflow, difference} of acc - a - bin.
  function automatic logic [WIDTH+1:0] sub_f(input logic [WIDTH-1:0] acc,
                                             input logic [WIDTH-1:0] a,
                                             input logic             bin);
    logic [WIDTH:0] d;
    logic           ovf;
    d   = {1'b0, acc} - {1'b0, a} - {{WIDTH{1'b0}}, bin};
    ovf = (acc[WIDTH-1] != a[WIDTH-1]) && (d[WIDTH-1] != acc[WIDTH-1]);
    return {d[WIDTH], ovf, d[WIDTH-1:0]};
  endfunction

  always_comb begin
    res   = y_p0;
    cbf_n = cbf_p0;
    of_n  = 1'b0;
    case (bus.Mode)
      M_LOAD: res = bus.A;
      M_ADD:  {cbf_n, of_n, res} = add_f(y_p0, bus.A, 1'b0);
      M_ADC:  {cbf_n, of_n, res} = add_f(y_p0, bus.A, bus.Cin);
      M_SUB:  {cbf_n, of_n, res} = sub_f(y_p0, bus.A, 1'b0);
      M_SBB:  {cbf_n, of_n, res} = sub_f(y_p0, bus.A, bus.Cin);
      M_AND:  res = y_p0 & bus.A;
      M_OR:   res = y_p0 | bus.A;
      M_XOR:  res = y_p0 ^ bus.A;
      M_NOT:  res = ~y_p0;
      M_SHL:  begin res = {y_p0[WIDTH-2:0], 1'b0};          cbf_n = y_p0[WIDTH-1]; end
      M_SHR:  begin res = {1'b0, y_p0[WIDTH-1:1]};          cbf_n = y_p0[0];       end
      M_ASR:  begin res = {y_p0[WIDTH-1], y_p0[WIDTH-1:1]}; cbf_n = y_p0[0];       end
      M_ROL:  begin res = {y_p0[WIDTH-2:0], cbf_p0};        cbf_n = y_p0[WIDTH-1]; end
      M_ROR:  begin res = {cbf_p0, y_p0[WIDTH-1:1]};        cbf_n = y_p0[0];       end
      default: ;
    endcase
  end

  // One shift-add step: add multiplicand into the upper half, then shift the pair right.
  assign mul_sum = {1'b0, part_p0} + (mplier_p0[0] ? {1'b0, mcand_p0} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], mplier_p0[WIDTH-1:1]};

  // Stage p0: multiplier datapath registers (no reset; qualified by state).
  always_ff @(negedge Clk) begin
    if (state_p0 == IDLE) begin
      if (bus.Start && bus.Mode == M_MUL) begin
        mcand_p0  <= bus.A;
        mplier_p0 <= y_p0;
        part_p0   <= '0;
      end
    end else begin
      part_p0   <= mul_hi;
      mplier_p0 <= mul_lo;
    end
  end

  // Stage p0: architectural state, flags and MUL control.
  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_p0 <= IDLE;
      y_p0     <= '0;
      hi_p0    <= '0;
      cbf_p0   <= 1'b0;
      of_p0    <= 1'b0;
      zf_p0    <= 1'b1;
      busy_p0  <= 1'b0;
      done_p0  <= 1'b0;
      cnt_p0   <= '0;
    end else begin
      done_p0 <= 1'b0;
      case (state_p0)
        IDLE: begin
          if (bus.Start) begin
            if (bus.Mode == M_MUL) begin
              state_p0 <= RUN;
              busy_p0  <= 1'b1;
              cnt_p0   <= CNTW'(WIDTH);
            end else begin
              done_p0 <= 1'b1;
              if (bus.Mode != M_NOP) begin
                y_p0   <= res;
                cbf_p0 <= cbf_n;
                of_p0  <= of_n;
                zf_p0  <= (res == '0);
              end
            end
          end
        end
        RUN: begin
          cnt_p0 <= cnt_p0 - CNTW'(1);
          if (cnt_p0 == CNTW'(1)) begin
            y_p0     <= mul_lo;
            hi_p0    <= mul_hi;
            of_p0    <= (mul_hi != '0);
            zf_p0    <= (mul_lo == '0);
            busy_p0  <= 1'b0;
            done_p0  <= 1'b1;
            state_p0 <= IDLE;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  assign bus.Y    = y_p0;
  assign bus.Hi   = hi_p0;
  assign bus.CBF  = cbf_p0;
  assign bus.Of   = of_p0;
  assign bus.Zf   = zf_p0;
  assign bus.Busy = busy_p0;
  assign bus.Done = done_p0;

endmodule

// File: tb/tb_accum_alu.sv
// Directed bench for accum_alu at WIDTH=4 with hand-computed expectations.
module tb_accum_alu;
  logic Clk;
  logic nReset;
  int   checks;
  int   errors;
  int   nb;
  int   seen_done;

  accum_alu_if #(.WIDTH(4)) bus ();

  accum_alu #(.WIDTH(4), .CNTW(3)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one falling edge, then sample just after that edge.
  task automatic op(input logic [3:0] mode, input logic [3:0] a, input logic cin);
    bus.Mode  = mode;
    bus.A     = a;
    bus.Cin   = cin;
    bus.Start = 1'b1;
    @(negedge Clk);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge Clk);
    #1;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.Done !== 1'b1 && cycles < 20) begin
      idle_cycle();
      cycles++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nReset = 1'b0;
    bus.A = '0; bus.Cin = 1'b0; bus.Mode = '0; bus.Start = 1'b0;
    #22;
    nReset = 1'b1;
    chk("rst_Y", bus.Y, 4'd0);
    chk("rst_Hi", bus.Hi, 4'd0);
    chk("rst_CBF", bus.CBF, 1'b0);
    chk("rst_Of", bus.Of, 1'b0);
    chk("rst_Zf", bus.Zf, 1'b1);
    chk("rst_Busy", bus.Busy, 1'b0);
    chk("rst_Done", bus.Done, 1'b0);

    // asynchronous reset between edges
    op(4'd1, 4'd9, 1'b0);
    chk("pre_async_Y", bus.Y, 4'd9);
    #2 nReset = 1'b0;
    #1;
    chk("async_Y", bus.Y, 4'd0);
    chk("async_Zf", bus.Zf, 1'b1);
    chk("async_Done", bus.Done, 1'b0);
    nReset = 1'b1;

    op(4'd1, 4'd7, 1'b0);
    op(4'd2, 4'd1, 1'b0);
    chk("add1_Y", bus.Y, 4'd8);
    chk("add1_CBF", bus.CBF, 1'b0);
    chk("add1_Of", bus.Of, 1'b1);
    chk("add1_Zf", bus.Zf, 1'b0);
    chk("add1_Done", bus.Done, 1'b1);
    idle_cycle();
    chk("add1_Done_drop", bus.Done, 1'b0);
    op(4'd2, 4'd8, 1'b0);
    chk("add8_Y", bus.Y, 4'd0);
    chk("add8_CBF", bus.CBF, 1'b1);
    chk("add8_Of", bus.Of, 1'b1);
    chk("add8_Zf", bus.Zf, 1'b1);

    op(4'd1, 4'd3, 1'b0);
    chk("load_keeps_CBF", bus.CBF, 1'b1);
    op(4'd4, 4'd5, 1'b0);
    chk("sub_Y", bus.Y, 4'd14);
    chk("sub_CBF", bus.CBF, 1'b1);
    chk("sub_Of", bus.Of, 1'b0);
    op(4'd5, 4'd13, 1'b1);
    chk("sbb_Y", bus.Y, 4'd0);
    chk("sbb_CBF", bus.CBF, 1'b0);
    chk("sbb_Zf", bus.Zf, 1'b1);
    op(4'd1, 4'd7, 1'b0);
    op(4'd3, 4'd8, 1'b1);
    chk("adc_Y", bus.Y, 4'd0);
    chk("adc_CBF", bus.CBF, 1'b1);

    op(4'd1, 4'b1011, 1'b0);
    op(4'd11, 4'd0, 1'b0);
    chk("shr_Y", bus.Y, 4'b0101);
    chk("shr_CBF", bus.CBF, 1'b1);
    op(4'd14, 4'd0, 1'b0);
    chk("ror_Y", bus.Y, 4'b1010);
    chk("ror_CBF", bus.CBF, 1'b1);
    op(4'd12, 4'd0, 1'b0);
    chk("asr_Y", bus.Y, 4'b1101);
    chk("asr_CBF", bus.CBF, 1'b0);
    op(4'd13, 4'd0, 1'b0);
    chk("rol_Y", bus.Y, 4'b1010);
    chk("rol_CBF", bus.CBF, 1'b1);
    op(4'd10, 4'd0, 1'b0);
    chk("shl_Y", bus.Y, 4'b0100);
    chk("shl_CBF", bus.CBF, 1'b1);
    op(4'd8, 4'b1111, 1'b0);
    chk("xor_Y", bus.Y, 4'b1011);
    op(4'd9, 4'd0, 1'b0);
    chk("not_Y", bus.Y, 4'b0100);
    op(4'd7, 4'b0011, 1'b0);
    chk("or_Y", bus.Y, 4'b0111);
    op(4'd6, 4'b1010, 1'b0);
    chk("and_Y", bus.Y, 4'b0010);
    chk("and_Of", bus.Of, 1'b0);
    op(4'd0, 4'd5, 1'b0);
    chk("nop_Y", bus.Y, 4'b0010);
    chk("nop_Done", bus.Done, 1'b1);

    // MUL 13*11 = 143 with CBF preset to 1 and an ignored ADD mid-run
    op(4'd1, 4'd15, 1'b0);
    op(4'd2, 4'd1, 1'b0);
    op(4'd1, 4'd13, 1'b0);
    op(4'd15, 4'd11, 1'b0);
    chk("mul_busy_start", bus.Busy, 1'b1);
    chk("mul_no_early_done", bus.Done, 1'b0);
    nb = 1;
    op(4'd2, 4'd1, 1'b0);
    chk("mul_ignore_Y", bus.Y, 4'd13);
    if (bus.Busy === 1'b1) nb++;
    for (int i = 0; i < 20; i++) begin
      idle_cycle();
      if (bus.Busy !== 1'b1) break;
      nb++;
    end
    chk("mul_busy_cycles", nb, 4);
    chk("mul_Done", bus.Done, 1'b1);
    chk("mul_Y", bus.Y, 4'd15);
    chk("mul_Hi", bus.Hi, 4'd8);
    chk("mul_Of", bus.Of, 1'b1);
    chk("mul_Zf", bus.Zf, 1'b0);
    chk("mul_CBF", bus.CBF, 1'b1);
    idle_cycle();
    chk("mul_Done_drop", bus.Done, 1'b0);
    chk("mul_no_queue_Y", bus.Y, 4'd15);

    // reset in the middle of a MUL
    op(4'd1, 4'd5, 1'b0);
    op(4'd15, 4'd3, 1'b0);
    idle_cycle();
    #2 nReset = 1'b0;
    #1;
    chk("mulrst_Y", bus.Y, 4'd0);
    chk("mulrst_Hi", bus.Hi, 4'd0);
    chk("mulrst_Busy", bus.Busy, 1'b0);
    nReset = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      idle_cycle();
      if (bus.Done === 1'b1) seen_done++;
    end
    chk("mulrst_no_Done", seen_done, 0);
    chk("mulrst_Y_hold", bus.Y, 4'd0);

    op(4'd1, 4'd2, 1'b0);
    op(4'd15, 4'd3, 1'b0);
    wait_done(nb);
    chk("mul2_Done", bus.Done, 1'b1);
    chk("mul2_Y", bus.Y, 4'd6);
    chk("mul2_Hi", bus.Hi, 4'd0);
    chk("mul2_Of", bus.Of, 1'b0);
    chk("mul2_Zf", bus.Zf, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
